genius_seq_ctrl: RTL and testbench

//  Round controller for the Genius (Simon-style) game. It drives `address` into the

---
 rtl/genius_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_genius_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_seq_ctrl.sv
// Genius (Simon-style) round controller: replays the first N ROM colours on the LEDs,
// then checks the player's presses in order, growing the sequence up to MAX_ROUND.
module genius_seq_ctrl #(
  parameter int SIZE      = 4,
  parameter int MAX_ROUND = 16,
  parameter int TIME_SHOW = 4,
  parameter int TIME_GAP  = 2,
  parameter int TIMEOUT   = 20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            jogada_valid,
  input  logic [SIZE-1:0] jogada,
  input  logic [SIZE-1:0] saida,
  output logic [SIZE-1:0] address,
  output logic [SIZE-1:0] leds,
  output logic [SIZE:0]   round,
  output logic            busy,
  output logic            win,
  output logic            lose
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW_ON  = 3'd1,
    SHOW_OFF = 3'd2,
    WAIT_IN  = 3'd3,
    WIN      = 3'd4,
    LOSE     = 3'd5
  } state_t;

  localparam logic [15:0]     SHOW_LAST  = 16'(TIME_SHOW - 1);
  localparam logic [15:0]     GAP_LAST   = 16'(TIME_GAP - 1);
  localparam logic [15:0]     WAIT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [SIZE:0]   LAST_ROUND = MAX_ROUND[SIZE:0];
  localparam logic [SIZE:0]   ROUND_ONE  = 1;
  localparam logic [SIZE-1:0] ADDR_ONE   = 1;

  state_t          state_q;
  logic [SIZE-1:0] address_q;
  logic [SIZE:0]   round_q;
  logic [15:0]     timer_q;

  logic [SIZE:0]   round_m1;
  logic            more_steps;
  logic            press_ok;
  logic [15:0]     timer_inc;

  assign round_m1   = round_q - ROUND_ONE;
  assign more_steps = {1'b0, address_q} < round_m1;
  // A zero or multi-hot press can never be a correct colour, whatever the ROM holds.
  assign press_ok   = (jogada == saida) && (jogada != '0) &&
                      ((jogada & (jogada - ADDR_ONE)) == '0);
  assign timer_inc  = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      address_q <= '0;
      round_q   <= '0;
      timer_q   <= '0;
    end else begin
      case (state_q)
        IDLE, WIN, LOSE: begin
          if (start) begin
            state_q   <= SHOW_ON;
            round_q   <= ROUND_ONE;
            address_q <= '0;
            timer_q   <= '0;
          end
        end
        SHOW_ON: begin
          if (timer_q == SHOW_LAST) begin
            state_q <= SHOW_OFF;
            timer_q <= '0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        SHOW_OFF: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            if (more_steps) begin
              address_q <= address_q + ADDR_ONE;
              state_q   <= SHOW_ON;
            end else begin
              address_q <= '0;
              state_q   <= WAIT_IN;
            end
          end else begin
            timer_q <= timer_inc;
          end
        end
        WAIT_IN: begin
          // A press on the timeout cycle takes precedence over the timeout.
          if (jogada_valid) begin
            if (!press_ok) begin
              state_q <= LOSE;
            end else if (more_steps) begin
              address_q <= address_q + ADDR_ONE;
              timer_q   <= '0;
            end else if (round_q < LAST_ROUND) begin
              round_q   <= round_q + ROUND_ONE;
              address_q <= '0;
              timer_q   <= '0;
              state_q   <= SHOW_ON;
            end else begin
              state_q <= WIN;
            end
          end else if (timer_q == WAIT_LAST) begin
            state_q <= LOSE;
          end else begin
            timer_q <= timer_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address = address_q;
  assign round   = round_q;
  assign leds    = (state_q == SHOW_ON) ? saida : '0;
  assign busy    = (state_q == SHOW_ON) || (state_q == SHOW_OFF) || (state_q == WAIT_IN);
  assign win     = (state_q == WIN);
  assign lose    = (state_q == LOSE);

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// Bench for genius_seq_ctrl: directed game scenarios plus randomized games checked
// against a cycle-timeline model of replay, input window, win and loss.
module tb_genius_seq_ctrl;
  localparam int SIZE  = 4;
  localparam int MAXR  = 4;
  localparam int TSHOW = 4;
  localparam int TGAP  = 2;
  localparam int TOUT  = 20;

  logic       clock = 1'b0;
  logic       reset, start, jogada_valid;
  logic [3:0] jogada, saida, address, leds;
  logic [4:0] round;
  logic       busy, win, lose;
  logic [3:0] rom [16];
  int         n_checks = 0;
  int         n_fail   = 0;

  assign saida = rom[address];

  genius_seq_ctrl #(
    .SIZE(SIZE), .MAX_ROUND(MAXR), .TIME_SHOW(TSHOW), .TIME_GAP(TGAP), .TIMEOUT(TOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .jogada_valid(jogada_valid),
    .jogada(jogada), .saida(saida), .address(address), .leds(leds), .round(round),
    .busy(busy), .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    jogada = v;
    jogada_valid = 1'b1;
    tick();
    jogada_valid = 1'b0;
    jogada = '0;
  endtask

  function automatic logic [3:0] bad_press(input logic [3:0] v);
    logic [3:0] rot;
    rot = {v[2:0], v[3]};
    case ($urandom_range(0, 2))
      0:       return 4'b0000;
      1:       return rot;
      default: return v | rot;
    endcase
  endfunction

  task automatic randomize_rom();
    for (int k = 0; k < 16; k++) rom[k] = 4'b0001 << $urandom_range(0, 3);
  endtask

  // Replay of round r: each step lit TSHOW cycles then dark TGAP cycles. Optional noise
  // on start/jogada_valid must have no effect while busy outside the input window.
  task automatic check_replay(input int r, input bit noise);
    logic [3:0] exp_leds;
    for (int k = 0; k < r; k++) begin
      for (int c = 0; c < TSHOW + TGAP; c++) begin
        if (noise) begin
          jogada_valid = 1'($urandom_range(0, 1));
          jogada       = 4'($urandom);
          start        = 1'($urandom_range(0, 1));
        end
        exp_leds = (c < TSHOW) ? rom[k] : 4'b0000;
        n_checks++;
        if ({leds, address, round, busy, win, lose} !== {exp_leds, 4'(k), 5'(r), 3'b100}) begin
          n_fail++;
          $display("FAIL replay r%0d step%0d cyc%0d: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp %b/%0d/%0d/100",
                   r, k, c, leds, address, round, busy, win, lose, exp_leds, k, r);
        end
        tick();
      end
    end
    jogada_valid = 1'b0;
    jogada = '0;
    start = 1'b0;
  endtask

  // d idle cycles in the input window, expecting step i of round r pending.
  task automatic wait_idle(input int d, input int r, input int i);
    for (int c = 0; c < d; c++) begin
      start = 1'($urandom_range(0, 1));
      n_checks++;
      if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'(i), 5'(r), 3'b100}) begin
        n_fail++;
        $display("FAIL wait r%0d i%0d c%0d: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/%0d/%0d/100",
                 r, i, c, leds, address, round, busy, win, lose, i, r);
      end
      tick();
    end
    start = 1'b0;
  endtask

  // mode 0: clear every round; 1: wrong press at (fr,fi); 2: timeout at (fr,fi)
  task automatic play_game(input int mode, input int fr, input int fi);
    int d;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= MAXR; r++) begin
      check_replay(r, 1'($urandom_range(0, 1)));
      for (int i = 0; i < r; i++) begin
        if (mode == 2 && r == fr && i == fi) begin
          wait_idle(TOUT, r, i);
          n_checks++;
          if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'(i), 5'(r), 3'b001}) begin
            n_fail++;
            $display("FAIL game_timeout r%0d i%0d: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/%0d/%0d/001",
                     r, i, leds, address, round, busy, win, lose, i, r);
          end
          return;
        end
        d = ($urandom_range(0, 7) == 0) ? TOUT - 1 : int'($urandom_range(0, 5));
        wait_idle(d, r, i);
        if (mode == 1 && r == fr && i == fi) begin
          press(bad_press(rom[i]));
          n_checks++;
          if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'(i), 5'(r), 3'b001}) begin
            n_fail++;
            $display("FAIL game_wrong r%0d i%0d: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/%0d/%0d/001",
                     r, i, leds, address, round, busy, win, lose, i, r);
          end
          return;
        end
        press(rom[i]);
      end
    end
    n_checks++;
    if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'(MAXR - 1), 5'(MAXR), 3'b010}) begin
      n_fail++;
      $display("FAIL game_win: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/%0d/%0d/010",
               leds, address, round, busy, win, lose, MAXR - 1, MAXR);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'd0, 5'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/0/0/000",
               leds, address, round, busy, win, lose);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_replay();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_replay(1, 1'b0);
    n_checks++;
    if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'd0, 5'd1, 3'b100}) begin
      n_fail++;
      $display("FAIL first_wait: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/0/1/100",
               leds, address, round, busy, win, lose);
    end
  endtask

  task automatic test_round_advance();
    press(4'b0001);
    check_replay(2, 1'b1);
    wait_idle(2, 2, 0);
    press(4'b0001);
    wait_idle(3, 2, 1);
    press(4'b1000);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      jogada_valid = 1'b1;
      jogada = 4'b0100;
      n_checks++;
      if ({leds, address, round, busy, win, lose} !== {4'b0001, 4'd0, 5'd3, 3'b100}) begin
        n_fail++;
        $display("FAIL show_ignore_press c%0d: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0001/0/3/100",
                 c, leds, address, round, busy, win, lose);
      end
      tick();
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    n_checks++;
    if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'd0, 5'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/0/0/000",
               leds, address, round, busy, win, lose);
    end
    reset = 1'b0;
    start = 1'b0;
    jogada_valid = 1'b0;
    jogada = '0;
    tick();
  endtask

  task automatic test_lose_mismatch();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_replay(1, 1'b0);
    press(4'b0001);
    check_replay(2, 1'b0);
    press(4'b0001);
    press(4'b0100);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({leds, address, round, busy, win, lose} !== {4'b0000, 4'd1, 5'd2, 3'b001}) begin
        n_fail++;
        $display("FAIL lose_hold c%0d: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0000/1/2/001",
                 c, leds, address, round, busy, win, lose);
      end
      jogada_valid = 1'b1;
      jogada = 4'b1000;
      tick();
    end
    jogada_valid = 1'b0;
    jogada = '0;
  endtask

  task automatic test_timeout();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_replay(1, 1'b0);
    wait_idle(TOUT, 1, 0);
    n_checks++;
    if ({leds, round, busy, win, lose} !== {4'b0000, 5'd1, 3'b001}) begin
      n_fail++;
      $display("FAIL timeout: leds/round/bwl got %b/%0d/%b%b%b exp 0000/1/001",
               leds, round, busy, win, lose);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_replay(1, 1'b0);
    wait_idle(TOUT - 1, 1, 0);
    press(4'b0001);
    check_replay(2, 1'b0);
    wait_idle(TOUT, 2, 0);
  endtask

  task automatic test_win();
    rom[3] = 4'b0010;
    play_game(0, 0, 0);
    jogada_valid = 1'b1;
    jogada = 4'b0001;
    tick();
    jogada_valid = 1'b0;
    jogada = '0;
    n_checks++;
    if ({leds, round, busy, win, lose} !== {4'b0000, 5'(MAXR), 3'b010}) begin
      n_fail++;
      $display("FAIL win_hold: leds/round/bwl got %b/%0d/%b%b%b exp 0000/%0d/010",
               leds, round, busy, win, lose, MAXR);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({leds, address, round, busy, win, lose} !== {4'b0001, 4'd0, 5'd1, 3'b100}) begin
      n_fail++;
      $display("FAIL win_restart: leds/addr/round/bwl got %b/%0d/%0d/%b%b%b exp 0001/0/1/100",
               leds, address, round, busy, win, lose);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_random_games();
    int mode, fr, fi;
    for (int g = 0; g < 10; g++) begin
      randomize_rom();
      mode = $urandom_range(0, 2);
      fr   = $urandom_range(1, MAXR);
      fi   = $urandom_range(0, fr - 1);
      play_game(mode, fr, fi);
      wait_idle(0, 0, 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    jogada_valid = 1'b0;
    jogada = '0;
    randomize_rom();
    rom[0] = 4'b0001;
    rom[1] = 4'b1000;
    rom[2] = 4'b0100;
    test_reset();
    test_first_replay();
    test_round_advance();
    test_reset_mid();
    test_lose_mismatch();
    test_timeout();
    test_win();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
